mm_arbiter: RTL and testbench

MM_ARBITER -- requirements
Module: mm_arbiter

---
 rtl/mm_arbiter_if.sv | 30 +++
 rtl/mm_arbiter.sv | 98 +++++++++
 tb/tb_mm_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mm_arbiter_if.sv
// rtl/mm_arbiter_if.sv - requester, result and multiplier signals of the matrix-multiply arbiter
interface mm_arbiter_if;
  logic        req0;
  logic        req1;
  logic [31:0] a0;
  logic [31:0] a1;
  logic [31:0] b0;
  logic [31:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic [67:0] res;
  logic        res_valid;
  logic        res_id;
  logic        err;
  logic        mm_start;
  logic [7:0]  mm_A;
  logic [7:0]  mm_B;
  logic [16:0] mm_out;
  logic        mm_out_strobe;

  modport slave (
    input  req0, req1, a0, a1, b0, b1, mm_out, mm_out_strobe,
    output gnt0, gnt1, res, res_valid, res_id, err, mm_start, mm_A, mm_B
  );

  modport master (
    output req0, req1, a0, a1, b0, b1, mm_out, mm_out_strobe,
    input  gnt0, gnt1, res, res_valid, res_id, err, mm_start, mm_A, mm_B
  );
endinterface

// File: rtl/mm_arbiter.sv
// rtl/mm_arbiter.sv - round-robin arbiter that streams 2x2 byte matrices to a multiplier and collects its result
module mm_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        RST,
  mm_arbiter_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ld_cnt;
  logic [2:0]    st_cnt, st_cnt_nxt;
  logic [WW-1:0] wait_cnt;
  logic          owner, last_gnt, win, timeout, strobe_ok;
  logic [31:0]   a_q, b_q;
  logic [67:0]   acc, acc_nxt, res_q;
  logic          res_id_q, err_q;

  always_comb begin
    state_nxt  = state;
    timeout    = 1'b0;
    strobe_ok  = bus.mm_out_strobe && (state == LOAD || state == WAIT) && (st_cnt < 3'd4);
    st_cnt_nxt = st_cnt + {2'b00, strobe_ok};
    acc_nxt    = acc;
    if (strobe_ok) acc_nxt[17*st_cnt[1:0] +: 17] = bus.mm_out;
    // a tie goes to whichever requester was not granted last
    win = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
    case (state)
      IDLE: if (bus.req0 || bus.req1) state_nxt = LOAD;
      LOAD: if (ld_cnt == 2'd3) state_nxt = (st_cnt_nxt == 3'd4) ? DONE : WAIT;
      WAIT: begin
        if (st_cnt_nxt == 3'd4) begin
          state_nxt = DONE;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
          state_nxt = DONE;
          timeout   = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= IDLE;
      ld_cnt   <= '0;
      st_cnt   <= '0;
      wait_cnt <= '0;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      res_q    <= '0;
      res_id_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      st_cnt <= st_cnt_nxt;
      acc    <= acc_nxt;
      case (state)
        IDLE: if (state_nxt == LOAD) begin
          owner    <= win;
          last_gnt <= win;
          a_q      <= win ? bus.a1 : bus.a0;
          b_q      <= win ? bus.b1 : bus.b0;
          ld_cnt   <= '0;
          st_cnt   <= '0;
          wait_cnt <= '0;
          acc      <= '0;
        end
        LOAD: ld_cnt <= ld_cnt + 2'd1;
        WAIT: wait_cnt <= wait_cnt + WW'(1);
        default: ;
      endcase
      // result register only moves on completion so it holds between pulses
      if (state != DONE && state_nxt == DONE) begin
        res_q    <= timeout ? '0 : acc_nxt;
        res_id_q <= owner;
        err_q    <= timeout;
      end
    end
  end

  assign bus.gnt0      = (state == LOAD) && (ld_cnt == 2'd0) && !owner;
  assign bus.gnt1      = (state == LOAD) && (ld_cnt == 2'd0) && owner;
  assign bus.mm_start  = (state == LOAD);
  assign bus.mm_A      = (state == LOAD) ? a_q[8*ld_cnt +: 8] : 8'd0;
  assign bus.mm_B      = (state == LOAD) ? b_q[8*ld_cnt +: 8] : 8'd0;
  assign bus.res       = res_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_valid = (state == DONE);
  assign bus.err       = (state == DONE) && err_q;
endmodule

// File: tb/tb_mm_arbiter.sv
// tb/tb_mm_arbiter.sv - self-checking bench for mm_arbiter
module tb_mm_arbiter;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic RST;
  int   total = 0;
  int   bad = 0;
  int   last_who;

  mm_arbiter_if bus ();
  mm_arbiter #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .RST(RST), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit          r0;
    bit          r1;
    logic [31:0] a0, b0, a1, b1;
    int          s0;
    int          nstr;
    int          who;
    logic [67:0] res;
    bit          err;
    int          lat;
  } vec_t;

  vec_t vt[8];

  function automatic logic [67:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {17'(c3), 17'(c2), 17'(c1), 17'(c0)};
  endfunction

  // C = A x B on row-major 2x2 byte matrices
  function automatic logic [67:0] mat_ref(input logic [31:0] a, input logic [31:0] b);
    int ae[4], be[4];
    for (int k = 0; k < 4; k++) begin
      ae[k] = int'(a[8*k +: 8]);
      be[k] = int'(b[8*k +: 8]);
    end
    return pk(ae[0]*be[0] + ae[1]*be[2], ae[0]*be[1] + ae[1]*be[3],
              ae[2]*be[0] + ae[3]*be[2], ae[2]*be[1] + ae[3]*be[3]);
  endfunction

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " gnt0"}, 68'(bus.gnt0), 68'd0);
    chk({tag, " gnt1"}, 68'(bus.gnt1), 68'd0);
    chk({tag, " res_valid"}, 68'(bus.res_valid), 68'd0);
    chk({tag, " err"}, 68'(bus.err), 68'd0);
    chk({tag, " mm_start"}, 68'(bus.mm_start), 68'd0);
    chk({tag, " mm_A"}, 68'(bus.mm_A), 68'd0);
    chk({tag, " mm_B"}, 68'(bus.mm_B), 68'd0);
    chk({tag, " res"}, bus.res, 68'd0);
    chk({tag, " res_id"}, 68'(bus.res_id), 68'd0);
  endtask

  // Requests a job, plays the multiplier (strobe n at cycle s0+n counted from the grant cycle) and checks the outcome.
  task automatic run_job(input string tag, input bit r0, input bit r1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input int s0, input int nstr,
                         input int exp_who, input logic [67:0] exp_res, input bit exp_err, input int exp_lat);
    logic [31:0] sa, sb, am, bm;
    logic [67:0] cm, r;
    int          waitc, pulses, lat, who, n;
    bit          gnt_ok, start_ok, err_ok, rid, e;
    bus.a0 = a0; bus.b0 = b0; bus.a1 = a1; bus.b1 = b1;
    bus.req0 = r0; bus.req1 = r1;
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!(bus.gnt0 || bus.gnt1) && waitc < 20);
    chk({tag, " grant seen"}, 68'(bus.gnt0 || bus.gnt1), 68'd1);
    if (!(bus.gnt0 || bus.gnt1)) begin
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      return;
    end
    who = bus.gnt1 ? 1 : 0;
    gnt_ok = bus.gnt0 ^ bus.gnt1;
    if (who == 1) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    am = who ? a1 : a0;
    bm = who ? b1 : b0;
    cm = mat_ref(am, bm);
    sa = '0; sb = '0; r = '0; rid = 1'b0; e = 1'b0;
    start_ok = 1'b1; err_ok = 1'b1; pulses = 0; lat = -1;
    for (int c = 0; c < 4 + TIMEOUT + 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 4) begin
        sa[8*c +: 8] = bus.mm_A;
        sb[8*c +: 8] = bus.mm_B;
        if (!bus.mm_start) start_ok = 1'b0;
      end else if (bus.mm_start || bus.mm_A != 8'd0 || bus.mm_B != 8'd0) begin
        start_ok = 1'b0;
      end
      if (c == 1 && (bus.gnt0 || bus.gnt1)) gnt_ok = 1'b0;
      if (bus.err && !bus.res_valid) err_ok = 1'b0;
      if (bus.res_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = c; r = bus.res; rid = bus.res_id; e = bus.err;
        end
      end
      n = c - s0;
      if (n >= 0 && n < nstr) begin
        bus.mm_out_strobe = 1'b1;
        bus.mm_out = (n < 4) ? cm[17*n +: 17] : 17'h1abcd;
      end else begin
        bus.mm_out_strobe = 1'b0;
        bus.mm_out = '0;
      end
      if (lat >= 0 && c >= lat + 1 && n >= nstr) break;
    end
    bus.mm_out_strobe = 1'b0;
    chk({tag, " who"}, 68'(who), 68'(exp_who));
    chk({tag, " gnt one-hot single cycle"}, 68'(gnt_ok), 68'd1);
    chk({tag, " A stream"}, 68'(sa), 68'(am));
    chk({tag, " B stream"}, 68'(sb), 68'(bm));
    chk({tag, " mm_start window"}, 68'(start_ok), 68'd1);
    chk({tag, " latency"}, 68'(lat), 68'(exp_lat));
    chk({tag, " res"}, r, exp_res);
    chk({tag, " res_id"}, 68'(rid), 68'(exp_who));
    chk({tag, " err"}, 68'(e), 68'(exp_err));
    chk({tag, " err only with pulse"}, 68'(err_ok), 68'd1);
    chk({tag, " pulse count"}, 68'(pulses), 68'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          wc, pulses, v, s0, nstr, who;
    bit          r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [67:0] held;

    vt[0] = '{1'b1, 1'b1, 32'h01000001, 32'h04030201, 32'h02020202, 32'h01010101, 5, 4, 0, pk(1, 2, 3, 4), 1'b0, 9};
    vt[1] = '{1'b1, 1'b1, 32'h01000001, 32'h04030201, 32'h02020202, 32'h01010101, 5, 4, 1, pk(4, 4, 4, 4), 1'b0, 9};
    vt[2] = '{1'b1, 1'b1, 32'h01000001, 32'h04030201, 32'h02020202, 32'h01010101, 5, 4, 0, pk(1, 2, 3, 4), 1'b0, 9};
    vt[3] = '{1'b1, 1'b0, 32'h04030201, 32'h08070605, 32'h0, 32'h0, 6, 4, 0, pk(19, 22, 43, 50), 1'b0, 10};
    vt[4] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'hffffffff, 32'hffffffff, 4, 4, 1, pk(130050, 130050, 130050, 130050), 1'b0, 8};
    vt[5] = '{1'b1, 1'b0, 32'h04030201, 32'h01000001, 32'h0, 32'h0, 0, 4, 0, pk(1, 2, 3, 4), 1'b0, 4};
    vt[6] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h11223344, 32'h55667788, 4, 3, 1, 68'd0, 1'b1, 4 + TIMEOUT};
    vt[7] = '{1'b1, 1'b0, 32'hffffffff, 32'h01010101, 32'h0, 32'h0, 4, 5, 0, pk(510, 510, 510, 510), 1'b0, 8};

    RST = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
    bus.mm_out = '0; bus.mm_out_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    RST = 1'b0;
    last_who = 1;

    for (int i = 0; i < 8; i++) begin
      run_job($sformatf("vec%0d", i), vt[i].r0, vt[i].r1, vt[i].a0, vt[i].b0, vt[i].a1, vt[i].b1,
              vt[i].s0, vt[i].nstr, vt[i].who, vt[i].res, vt[i].err, vt[i].lat);
      last_who = vt[i].who;
    end

    // strobes while idle must not disturb the held result
    held = pk(510, 510, 510, 510);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      bus.mm_out_strobe = (k < 3);
      bus.mm_out = 17'($urandom);
      @(negedge clk);
      if (bus.res_valid) pulses++;
    end
    bus.mm_out_strobe = 1'b0;
    chk("idle strobes pulses", 68'(pulses), 68'd0);
    chk("idle strobes res", bus.res, held);
    chk("idle strobes res_id", 68'(bus.res_id), 68'd0);

    // reset while waiting on the multiplier drops the job
    bus.a0 = 32'h04030201; bus.b0 = 32'h08070605;
    bus.req0 = 1'b1;
    wc = 0;
    do begin
      @(negedge clk);
      wc++;
    end while (!bus.gnt0 && wc < 20);
    chk("rst job gnt0", 68'(bus.gnt0), 68'd1);
    bus.req0 = 1'b0;
    repeat (6) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    check_quiet("mid reset");
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      bus.mm_out_strobe = (k < 4);
      bus.mm_out = 17'(k + 1);
      @(negedge clk);
      if (bus.res_valid) pulses++;
    end
    bus.mm_out_strobe = 1'b0;
    chk("late strobes pulses", 68'(pulses), 68'd0);
    chk("late strobes res", bus.res, 68'd0);
    last_who = 1;
    run_job("after reset req1", 1'b0, 1'b1, 32'h0, 32'h0, 32'h04030201, 32'h08070605,
            3, 4, 1, pk(19, 22, 43, 50), 1'b0, 7);

    for (int i = 0; i < 10; i++) begin
      v = $urandom_range(1, 3);
      r0 = v[0]; r1 = v[1];
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      s0 = $urandom_range(0, 8);
      nstr = ($urandom_range(0, 4) == 0) ? 3 : 4;
      who = (r0 && r1) ? (1 - last_who) : (r1 ? 1 : 0);
      run_job($sformatf("rand%0d", i), r0, r1, a0, b0, a1, b1, s0, nstr, who,
              (nstr >= 4) ? mat_ref(who ? a1 : a0, who ? b1 : b0) : 68'd0,
              nstr < 4, (nstr >= 4) ? s0 + 4 : 4 + TIMEOUT);
      last_who = who;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
